// File: rtl/life_pkg.sv
// Shared definitions for the 8x8 life sequencer: state encoding and tile geometry.
package life_pkg;

   localparam int TILE_CNT  = 4;
   localparam int TILE_BITS = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/life_gen_timer.sv
// Generation timer: counts 0..GEN_PERIOD-1 while enabled, wraps with a terminal-count pulse.
module life_gen_timer #(
   parameter int GEN_PERIOD = 25000000,
   parameter int CNT_W      = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tc
);

   logic [CNT_W-1:0] r_count;
   logic             w_at_end;

   assign w_at_end = (r_count == CNT_W'(GEN_PERIOD - 1));
   // Clear wins so a step is never issued in the cycle the timer is being restarted.
   assign o_tc     = i_enable & ~i_clear & w_at_end;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= w_at_end ? '0 : r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/life_sequencer_8x8.sv
// Sequencer for an external 8x8 life array: pattern load, timed/single generation steps, tile readout.
//   state  | meaning
//   S_IDLE | stopped; single_step allowed
//   S_LOAD | accepting 4 tile words, stepping suppressed
//   S_RUN  | free-running steps every GEN_PERIOD cycles
module life_sequencer_8x8
   import life_pkg::*;
#(
   parameter int GEN_PERIOD = 25000000,
   parameter int CNT_W      = 25
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 single_step,
   input  logic                 load_start,
   input  logic [TILE_BITS-1:0] load_data,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic                 rd_req,
   input  logic [1:0]           rd_tile,
   output logic [TILE_BITS-1:0] rd_data,
   output logic [TILE_BITS-1:0] rd_data_prev,
   output logic                 rd_valid,
   output logic [TILE_BITS-1:0] arr_vali,
   output logic [1:0]           arr_vali_selector,
   output logic                 arr_write_enb,
   output logic                 arr_step,
   output logic [1:0]           arr_valo_selector,
   input  logic [TILE_BITS-1:0] arr_valo,
   input  logic [TILE_BITS-1:0] arr_valo_prev,
   output logic                 busy,
   output logic [15:0]          gen_count
);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [1:0]           r_word_idx;
   logic [TILE_BITS-1:0] r_arr_vali;
   logic [1:0]           r_arr_vali_sel;
   logic                 r_arr_write_enb;
   logic                 r_arr_step;
   logic [15:0]          r_gen_count;
   logic [1:0]           r_arr_valo_sel;
   logic                 r_rd_pend;
   logic                 r_rd_valid;
   logic [TILE_BITS-1:0] r_rd_data;
   logic [TILE_BITS-1:0] r_rd_data_prev;

   logic w_accept;
   logic w_last_word;
   logic w_tmr_clear;
   logic w_tmr_en;
   logic w_tc;
   logic w_single;
   logic w_step_req;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = (r_state == S_LOAD) && load_valid;
      w_last_word = w_accept && (r_word_idx == 2'(TILE_CNT - 1));
      case (r_state)
         S_IDLE:  if (load_start) w_state_nxt = S_LOAD;
                  else if (run)   w_state_nxt = S_RUN;
         S_RUN:   if (load_start) w_state_nxt = S_LOAD;
                  else if (!run)  w_state_nxt = S_IDLE;
         S_LOAD:  if (w_last_word) w_state_nxt = run ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Timer only runs while staying in RUN; any entry or exit restarts it from 0.
   assign w_tmr_en    = (r_state == S_RUN);
   assign w_tmr_clear = !((r_state == S_RUN) && (w_state_nxt == S_RUN));
   assign w_single    = (r_state == S_IDLE) && !run && single_step && !load_start;
   assign w_step_req  = w_tc | w_single;

   life_gen_timer #(
      .GEN_PERIOD (GEN_PERIOD),
      .CNT_W      (CNT_W)
   ) u_gen_timer (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_tmr_clear),
      .i_enable (w_tmr_en),
      .o_tc     (w_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_word_idx      <= '0;
         r_arr_vali      <= '0;
         r_arr_vali_sel  <= '0;
         r_arr_write_enb <= 1'b0;
         r_arr_step      <= 1'b0;
         r_gen_count     <= '0;
         r_arr_valo_sel  <= '0;
         r_rd_pend       <= 1'b0;
         r_rd_valid      <= 1'b0;
         r_rd_data       <= '0;
         r_rd_data_prev  <= '0;
      end else begin
         r_state         <= w_state_nxt;
         r_arr_write_enb <= w_accept;
         if (w_accept) begin
            r_arr_vali     <= load_data;
            r_arr_vali_sel <= r_word_idx;
            r_word_idx     <= r_word_idx + 2'd1;
         end else if (r_state != S_LOAD) begin
            r_word_idx     <= '0;
         end
         r_arr_step <= w_step_req;
         if (w_step_req) r_gen_count <= r_gen_count + 16'd1;
         // Capture samples the array before any coincident step takes effect.
         r_rd_valid <= r_rd_pend;
         if (r_rd_pend) begin
            r_rd_data      <= arr_valo;
            r_rd_data_prev <= arr_valo_prev;
            r_rd_pend      <= 1'b0;
         end else if (rd_req) begin
            r_arr_valo_sel <= rd_tile;
            r_rd_pend      <= 1'b1;
         end
      end
   end

   assign load_ready        = (r_state == S_LOAD);
   assign busy              = (r_state != S_IDLE);
   assign arr_vali          = r_arr_vali;
   assign arr_vali_selector = r_arr_vali_sel;
   assign arr_write_enb     = r_arr_write_enb;
   assign arr_step          = r_arr_step;
   assign gen_count         = r_gen_count;
   assign arr_valo_selector = r_arr_valo_sel;
   assign rd_valid          = r_rd_valid;
   assign rd_data           = r_rd_data;
   assign rd_data_prev      = r_rd_data_prev;

endmodule

// File: tb/tb_life_sequencer_8x8.sv
// Directed bench for life_sequencer_8x8 with a tiny array model and write/read scoreboards.
module tb_life_sequencer_8x8;

   localparam int GP = 4;

   logic        clk = 1'b0;
   logic        reset, run, single_step, load_start, load_valid, rd_req;
   logic [15:0] load_data;
   logic [1:0]  rd_tile;
   logic        load_ready, rd_valid, arr_write_enb, arr_step, busy;
   logic [15:0] rd_data, rd_data_prev, arr_vali, arr_valo, arr_valo_prev, gen_count;
   logic [1:0]  arr_vali_selector, arr_valo_selector;

   logic [15:0] tile_mem [4] = '{default: 16'h0};
   logic [15:0] prev_mem [4] = '{default: 16'h0};
   bit          ovr_en = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int steps = 0;
   int cyc = 0;
   int last_step = 0;
   bit seen_step = 1'b0;
   logic [31:0] wq[$];
   logic [31:0] rq[$];

   life_sequencer_8x8 #(.GEN_PERIOD(GP), .CNT_W(25)) dut (
      .clk(clk), .reset(reset), .run(run), .single_step(single_step),
      .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
      .load_ready(load_ready), .rd_req(rd_req), .rd_tile(rd_tile),
      .rd_data(rd_data), .rd_data_prev(rd_data_prev), .rd_valid(rd_valid),
      .arr_vali(arr_vali), .arr_vali_selector(arr_vali_selector),
      .arr_write_enb(arr_write_enb), .arr_step(arr_step),
      .arr_valo_selector(arr_valo_selector), .arr_valo(arr_valo),
      .arr_valo_prev(arr_valo_prev), .busy(busy), .gen_count(gen_count)
   );

   always #5 clk = ~clk;

   // Array model: write stores a tile, step copies to prev and inverts.
   assign arr_valo      = (ovr_en && arr_valo_selector == 2'd2) ? 16'hA5A5 : tile_mem[arr_valo_selector];
   assign arr_valo_prev = (ovr_en && arr_valo_selector == 2'd2) ? 16'h5A5A : prev_mem[arr_valo_selector];

   always @(posedge clk) begin
      if (arr_write_enb) begin
         tile_mem[arr_vali_selector] <= arr_vali;
      end else if (arr_step) begin
         for (int i = 0; i < 4; i++) begin
            prev_mem[i] <= tile_mem[i];
            tile_mem[i] <= ~tile_mem[i];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      logic [31:0] e;
      cyc++;
      if (!reset) begin
         if (arr_write_enb) begin
            chk("write_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
               e = wq.pop_front();
               chk("write", {14'd0, arr_vali_selector, arr_vali}, e);
            end
         end
         if (rd_valid) begin
            chk("read_expected", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) begin
               e = rq.pop_front();
               chk("read", {rd_data, rd_data_prev}, e);
            end
         end
         if (arr_step) begin
            steps++;
            if (seen_step) chk("step_spacing", 32'((cyc - last_step) >= GP), 32'd1);
            last_step = cyc;
            seen_step = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] words [4];
      words = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
      reset = 1'b1; run = 1'b0; single_step = 1'b0; load_start = 1'b0;
      load_valid = 1'b0; load_data = 16'h0; rd_req = 1'b0; rd_tile = 2'd0;
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gen_count", 32'(gen_count), 32'd0);
      chk("rst_load_ready", 32'(load_ready), 32'd0);
      chk("rst_strobes", {29'd0, arr_write_enb, arr_step, rd_valid}, 32'd0);
      chk("rst_vali", {14'd0, arr_vali_selector, arr_vali}, 32'd0);
      chk("rst_rd_data", {rd_data, rd_data_prev}, 32'd0);
      chk("rst_valo_sel", 32'(arr_valo_selector), 32'd0);
      reset = 1'b0;
      tick();

      // Four back-to-back words, run=0
      load_start = 1'b1; tick(); load_start = 1'b0;
      chk("load_ready", 32'(load_ready), 32'd1);
      chk("load_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1; load_data = words[i];
         wq.push_back({14'd0, 2'(i), words[i]});
         tick();
      end
      load_valid = 1'b0;
      tick(); tick();
      chk("load_done_idle", 32'(busy), 32'd0);
      chk("load1_writes_drained", 32'(wq.size()), 32'd0);

      // Single step in IDLE
      single_step = 1'b1; tick(); single_step = 1'b0;
      chk("single_step_pulse", 32'(arr_step), 32'd1);
      chk("single_gen_count", 32'(gen_count), 32'd1);
      tick();
      chk("single_step_end", 32'(arr_step), 32'd0);
      chk("single_steps", 32'(steps), 32'd1);

      // Run 20 cycles: steps 4 cycles after entry, then every 4; single_step ignored
      run = 1'b1;
      for (int i = 0; i < 20; i++) begin
         single_step = (i == 10);
         tick();
      end
      single_step = 1'b0; run = 1'b0;
      tick(); tick();
      chk("run_steps", 32'(steps), 32'd5);
      chk("run_gen_count", 32'(gen_count), 32'd5);
      chk("run_stop_idle", 32'(busy), 32'd0);

      // load_start at timer=GP-2 in RUN; stray load_valid in RUN is ignored
      run = 1'b1; load_valid = 1'b1; load_data = 16'hDEAD;
      tick(); tick(); tick();
      load_valid = 1'b0; load_start = 1'b1; tick(); load_start = 1'b0;
      chk("run_load_ready", 32'(load_ready), 32'd1);
      load_valid = 1'b1; load_data = 16'h1111; wq.push_back({16'h0000, 16'h1111}); tick();
      load_valid = 1'b0; load_start = 1'b1; tick(); load_start = 1'b0;
      load_valid = 1'b1; load_data = 16'h2222; wq.push_back({16'h0001, 16'h2222}); tick();
      load_data = 16'h3333; wq.push_back({16'h0002, 16'h3333}); tick();
      load_data = 16'h4444; wq.push_back({16'h0003, 16'h4444}); tick();
      load_valid = 1'b0;
      chk("load_no_step", 32'(steps), 32'd5);
      chk("load_back_to_run", 32'(busy), 32'd1);
      tick(); tick(); tick();
      chk("restart_no_early_step", 32'(arr_step), 32'd0);
      tick();
      chk("restart_step_at_period", 32'(arr_step), 32'd1);
      run = 1'b0;
      tick(); tick();
      chk("load2_steps", 32'(steps), 32'd6);
      chk("load2_gen_count", 32'(gen_count), 32'd6);
      chk("load2_writes_drained", 32'(wq.size()), 32'd0);

      // Readout of tile 2; second request while outstanding is dropped
      ovr_en = 1'b1;
      rd_req = 1'b1; rd_tile = 2'd2; rq.push_back({16'hA5A5, 16'h5A5A}); tick();
      rd_tile = 2'd1;
      chk("rd_selector", 32'(arr_valo_selector), 32'd2);
      chk("rd_not_yet_valid", 32'(rd_valid), 32'd0);
      tick(); rd_req = 1'b0;
      chk("rd_valid_latency2", 32'(rd_valid), 32'd1);
      tick(); tick();
      ovr_en = 1'b0;
      chk("rd_queue_drained", 32'(rq.size()), 32'd0);

      rd_req = 1'b1; rd_tile = 2'd3; rq.push_back({16'hBBBB, 16'h4444}); tick();
      rd_req = 1'b0; tick(); tick();

      // Capture coincides with a step: pre-step contents expected
      rd_req = 1'b1; rd_tile = 2'd0; single_step = 1'b1; rq.push_back({16'hEEEE, 16'h1111}); tick();
      rd_req = 1'b0; single_step = 1'b0;
      tick(); tick();
      chk("prestep_gen_count", 32'(gen_count), 32'd7);
      chk("reads_drained", 32'(rq.size()), 32'd0);

      // Reset mid-load, then reload restarts at tile 0
      load_start = 1'b1; tick(); load_start = 1'b0;
      load_valid = 1'b1; load_data = 16'h0F0F; wq.push_back({16'h0000, 16'h0F0F}); tick();
      load_data = 16'hF0F0; wq.push_back({16'h0001, 16'hF0F0}); tick();
      load_valid = 1'b0;
      @(negedge clk); #1;
      reset = 1'b1; #1;
      chk("midload_rst_busy", 32'(busy), 32'd0);
      chk("midload_rst_ready", 32'(load_ready), 32'd0);
      chk("midload_rst_gen", 32'(gen_count), 32'd0);
      chk("midload_rst_vali", {13'd0, arr_write_enb, arr_vali_selector, arr_vali}, 32'd0);
      chk("midload_rst_rd", {rd_data, rd_data_prev}, 32'd0);
      tick(); reset = 1'b0; tick();
      load_start = 1'b1; tick(); load_start = 1'b0;
      load_valid = 1'b1; load_data = 16'hBEEF; wq.push_back({16'h0000, 16'hBEEF}); tick();
      load_valid = 1'b0;
      tick(); tick();
      chk("reload_still_loading", 32'(busy), 32'd1);
      chk("reload_writes_drained", 32'(wq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/life_sequencer_8x8.md
LIFE_SEQUENCER_8X8 -- requirements
Module: life_sequencer_8x8

Interface
REQ-001 Parameter GEN_PERIOD, default 25000000, clock cycles between generation steps in run mode; legal range 2..2^25-1.
REQ-002 Parameter CNT_W, default 25, width of the generation timer.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  level; 1 = free-running generation stepping.
REQ-006 single_step  input  1  one-cycle pulse; requests one generation step when run=0.
REQ-007 load_start  input  1  one-cycle pulse; begins a 4-tile pattern load.
REQ-008 load_data  input  16  tile pattern word, bit order as the 4x4 tile alive vector.
REQ-009 load_valid  input  1  load_data valid.
REQ-010 load_ready  output  1  sequencer accepts load_data this cycle.
REQ-011 rd_req  input  1  one-cycle readout request.
REQ-012 rd_tile  input  2  tile index to read, sampled with rd_req.
REQ-013 rd_data  output  16  registered tile alive vector.
REQ-014 rd_data_prev  output  16  registered tile previous-generation vector.
REQ-015 rd_valid  output  1  one-cycle pulse; rd_data/rd_data_prev valid.
REQ-016 arr_vali  output  16  write data to 8x8 array.
REQ-017 arr_vali_selector  output  2  tile written.
REQ-018 arr_write_enb  output  1  array write strobe.
REQ-019 arr_step  output  1  array generation-step strobe.
REQ-020 arr_valo_selector  output  2  tile selected for array readout.
REQ-021 arr_valo, arr_valo_prev  input  16 each  array combinational readout.
REQ-022 busy  output  1  high when state is not IDLE.
REQ-023 gen_count  output  16  number of steps issued since reset, wraps 0xFFFF->0.

Function
REQ-024 FSM states SHALL be IDLE, LOAD, RUN; one-hot or binary is free.
REQ-025 IDLE->LOAD on load_start (any state except LOAD); LOAD has priority over any step in that cycle.
REQ-026 In LOAD load_ready=1; each cycle with load_valid&load_ready SHALL register arr_vali=load_data, arr_vali_selector=word index, arr_write_enb=1 for exactly the next cycle.
REQ-027 Words SHALL map to tiles 0,1,2,3 in arrival order; after 4th accepted word, LOAD->RUN if run=1 else IDLE.
REQ-028 load_start while in LOAD SHALL be ignored; load_valid outside LOAD SHALL be ignored.
REQ-029 IDLE->RUN when run=1; RUN->IDLE when run=0, timer cleared.
REQ-030 Timer SHALL count 0..GEN_PERIOD-1 in RUN; at GEN_PERIOD-1 it wraps to 0 and arr_step=1 registered next cycle for one cycle.
REQ-031 Timer SHALL clear to 0 on entry to RUN and on entry to LOAD; no arr_step SHALL be issued in LOAD or in the cycle an arr_write_enb is high.
REQ-032 single_step in IDLE with run=0 SHALL produce one arr_step one cycle later; ignored in other states.
REQ-033 gen_count SHALL increment in the same cycle arr_step is high.
REQ-034 rd_req SHALL be served in any state: arr_valo_selector=rd_tile registered, rd_data/rd_data_prev captured next cycle, rd_valid pulses with them (latency 2 from rd_req).
REQ-035 If capture coincides with arr_step high, rd_data SHALL hold the pre-step value.
REQ-036 rd_req while a read is outstanding SHALL be ignored.

Reset
REQ-037 On reset: state IDLE, timer 0, gen_count 0, all strobes 0, load_ready 0, arr_vali 0, selectors 0, rd_data/rd_data_prev 0, busy 0.
REQ-038 Reset mid-LOAD SHALL abandon the load; tiles already written keep their contents (array reset is owned externally).

Structure
REQ-039 Shared package life_pkg SHALL hold the state encoding, TILE_CNT=4 and TILE_BITS=16.
REQ-040 Generation timer SHALL be sub-module life_gen_timer (clear, enable, terminal-count pulse).

Verification
REQ-041 Load 0x0001,0x0002,0x0004,0x0008 back-to-back with run=0 -> four arr_write_enb pulses, selectors 0..3, then IDLE, busy=0.
REQ-042 GEN_PERIOD=4, run=1 for 20 cycles -> arr_step every 4 cycles, gen_count=5 (+/-1 by phase), no double pulses.
REQ-043 load_start at timer=GEN_PERIOD-2 in RUN -> no arr_step until 4 words loaded, then timer restarts at 0.
REQ-044 run=0, single_step -> exactly one arr_step, gen_count +1; single_step during RUN -> no extra step.
REQ-045 rd_req tile 2 with arr_valo=0xA5A5 -> rd_valid two cycles later, rd_data=0xA5A5, arr_valo_selector=2.
REQ-046 Assert reset after 2 load words -> all outputs at reset values immediately; next load_start restarts at tile 0.
